// File: rtl/dual_slope_pkg.sv
// Shared types and defaults for the dual-slope ADC counting stage.
package dual_slope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INTEGRATE,
    INT_DONE,
    DEINTEGRATE,
    DONE
  } ds_state_t;

  localparam int DS_WIDTH = 10;
  localparam int DS_N_INT = 512;

  // The integration window must be reachable by a WIDTH-bit counter.
  function automatic bit n_int_legal(input int width, input int n_int);
    return (n_int >= 1) && (longint'(n_int) <= ((longint'(1) << width) - 1));
  endfunction

endpackage

// File: rtl/ds_up_counter.sv
// Saturating up-counter: clear beats load-1, load-1 beats enable; holds at all-ones.
module ds_up_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = &count;

  always_ff @(posedge clk) begin
    if (!reset_n)             count <= '0;
    else if (clr)             count <= '0;
    else if (load1)           count <= WIDTH'(1);
    else if (en && !at_max)   count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/dual_slope_counter.sv
// Dual-slope ADC counting stage: fixed integrate window, then timed de-integration.
// Optional DUAL_SLOPE_OVERFLOW_EN ends a conversion with an overflow flag at full scale.
module dual_slope_counter
  import dual_slope_pkg::*;
#(
  parameter int WIDTH = DS_WIDTH,
  parameter int N_INT = DS_N_INT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             count_clear,
  input  logic             enable_counting,
  input  logic             ch_Vmeasured,
  input  logic             ch_Vref,
  input  logic             cap_discharged,
  output logic             finished_counting,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  if (!n_int_legal(WIDTH, N_INT)) begin : g_bad_n_int
    $error("dual_slope_counter: N_INT outside 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N_INT - 1);

  ds_state_t        state;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             start, int_last, phase_sw;
  logic             cnt_clr, cnt_load1, cnt_en;

  always_comb begin
    start     = (state == IDLE) && enable_counting && ch_Vmeasured;
    int_last  = (state == INTEGRATE) && enable_counting && (count == LAST);
    phase_sw  = (state == INT_DONE) && enable_counting && ch_Vref;
    // A one-cycle window finishes on the entry cycle itself, so clear instead of load.
    cnt_clr   = count_clear || int_last || phase_sw || (start && N_INT == 1);
    cnt_load1 = start;
    cnt_en    = ((state == INTEGRATE) && enable_counting) ||
                ((state == DEINTEGRATE) && enable_counting && !cap_discharged && !at_max);
  end

  ds_up_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .load1  (cnt_load1),
    .en     (cnt_en),
    .count  (count),
    .at_max (at_max)
  );

`ifdef DUAL_SLOPE_OVERFLOW_EN
  logic overflow_q;
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      finished_counting <= 1'b0;
      result            <= '0;
      result_valid      <= 1'b0;
`ifdef DUAL_SLOPE_OVERFLOW_EN
      overflow_q        <= 1'b0;
`endif
    end else if (count_clear) begin
      state             <= IDLE;
      finished_counting <= 1'b0;
      result_valid      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
`ifdef DUAL_SLOPE_OVERFLOW_EN
          overflow_q <= 1'b0;
`endif
          if (N_INT == 1) begin
            finished_counting <= 1'b1;
            state             <= INT_DONE;
          end else begin
            state <= INTEGRATE;
          end
        end
        INTEGRATE: if (int_last) begin
          finished_counting <= 1'b1;
          state             <= INT_DONE;
        end
        INT_DONE: if (phase_sw) begin
          finished_counting <= 1'b0;
          state             <= DEINTEGRATE;
        end
        DEINTEGRATE: begin
          // Discharge takes precedence over reaching full scale.
          if (cap_discharged) begin
            result       <= count;
            result_valid <= 1'b1;
            state        <= DONE;
          end
`ifdef DUAL_SLOPE_OVERFLOW_EN
          else if (enable_counting && at_max) begin
            result       <= '1;
            overflow_q   <= 1'b1;
            result_valid <= 1'b1;
            state        <= DONE;
          end
`endif
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_slope_counter.sv
// Randomized bench for dual_slope_counter with a phase/tally reference model and directed scenarios.
module tb_dual_slope_counter;

  localparam int W     = 10;
  localparam int NI    = 512;
  localparam int MAXV  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n, count_clear, enable_counting, ch_Vmeasured, ch_Vref, cap_discharged;
  logic         finished_counting, result_valid, overflow;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  dual_slope_counter #(.WIDTH(W), .N_INT(NI)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .count_clear      (count_clear),
    .enable_counting  (enable_counting),
    .ch_Vmeasured     (ch_Vmeasured),
    .ch_Vref          (ch_Vref),
    .cap_discharged   (cap_discharged),
    .finished_counting(finished_counting),
    .result           (result),
    .result_valid     (result_valid),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: conversion phase plus a plain integer tally of enabled cycles.
  localparam int PH_IDLE = 0, PH_INT = 1, PH_WAIT = 2, PH_DEINT = 3, PH_DONE = 4;
  int phase = PH_IDLE;
  int tally = 0;
  int m_res = 0;
  bit m_fin = 0, m_vld = 0, m_ovf = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      phase = PH_IDLE; tally = 0; m_fin = 0; m_res = 0; m_vld = 0; m_ovf = 0;
    end else if (count_clear) begin
      phase = PH_IDLE; tally = 0; m_fin = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (phase == PH_IDLE) begin
        if (enable_counting && ch_Vmeasured) begin
          m_ovf = 0;
          tally = 1;
          phase = PH_INT;
          if (tally == NI) begin m_fin = 1; tally = 0; phase = PH_WAIT; end
        end
      end else if (phase == PH_INT) begin
        if (enable_counting) begin
          tally++;
          if (tally == NI) begin m_fin = 1; tally = 0; phase = PH_WAIT; end
        end
      end else if (phase == PH_WAIT) begin
        if (enable_counting && ch_Vref) begin m_fin = 0; tally = 0; phase = PH_DEINT; end
      end else if (phase == PH_DEINT) begin
        if (cap_discharged) begin
          m_res = tally; m_vld = 1; phase = PH_DONE;
        end else if (enable_counting) begin
          if (tally < MAXV) tally++;
`ifdef DUAL_SLOPE_OVERFLOW_EN
          else begin m_res = MAXV; m_ovf = 1; m_vld = 1; phase = PH_DONE; end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks += 4;
      if (finished_counting !== m_fin) begin
        errors++; $display("FAIL cyc_finished t=%0t got=%0b want=%0b", $time, finished_counting, m_fin);
      end
      if (result !== W'(m_res)) begin
        errors++; $display("FAIL cyc_result t=%0t got=%0d want=%0d", $time, result, m_res);
      end
      if (result_valid !== m_vld) begin
        errors++; $display("FAIL cyc_valid t=%0t got=%0b want=%0b", $time, result_valid, m_vld);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL cyc_overflow t=%0t got=%0b want=%0b", $time, overflow, m_ovf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit en, input bit vm, input bit vr, input bit cap);
    reset_n = !rst; count_clear = clr; enable_counting = en;
    ch_Vmeasured = vm; ch_Vref = vr; cap_discharged = cap;
    @(posedge clk);
    #1;
  endtask

  // Integrate from IDLE until finished_counting rises; returns steps taken including entry.
  task automatic integrate(input int gaps, output int n);
    int gaps_left;
    gaps_left = gaps;
    step(0, 0, 1, 1, 0, 0);
    n = 1;
    while (!finished_counting && n < 2000) begin
      if (gaps_left > 0 && (($urandom % 8) == 0 || n >= 400)) begin
        step(0, 0, 0, $urandom % 2, $urandom % 2, $urandom % 2);
        gaps_left--;
      end else begin
        step(0, 0, 1, 1, $urandom % 2, $urandom % 2);
      end
      n++;
    end
  endtask

  int  n, en_cnt, prev_res;
  bit  saw_vld, en_b;

  initial begin
    step(1, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
    check("rst_finished", finished_counting, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overflow", overflow, 0);

    // Full window, no gaps (cap toggles randomly during integrate and must be ignored)
    integrate(0, n);
    check("int_window", n, 512);

    // Half-scale de-integration with random enable gaps
    step(0, 0, 1, 0, 1, 0);
    check("fin_falls", finished_counting, 0);
    en_cnt = 0;
    while (en_cnt < 256) begin
      en_b = ($urandom % 4) != 0;
      step(0, 0, en_b, $urandom % 2, $urandom % 2, 0);
      if (en_b) en_cnt++;
    end
    step(0, 0, $urandom % 2, 0, 0, 1);
    check("half_result", result, 256);
    check("half_valid", result_valid, 1);
    check("half_overflow", overflow, 0);
    step(0, 0, 1, 1, 1, 0);
    check("valid_one_cycle", result_valid, 0);

    // Window with 10 enable gaps, then never discharge
    step(0, 1, 0, 0, 0, 0);
    integrate(10, n);
    check("int_window_gaps", n, 522);
    step(0, 0, 1, 0, 1, 0);
    saw_vld = 0;
    for (int i = 0; i < 1100; i++) begin
      step(0, 0, 1, 0, 0, 0);
      if (result_valid) saw_vld = 1;
    end
`ifdef DUAL_SLOPE_OVERFLOW_EN
    check("ovf_valid_seen", saw_vld, 1);
    check("ovf_result", result, 1023);
    check("ovf_flag", overflow, 1);
    prev_res = 1023;
`else
    check("noovf_valid_seen", saw_vld, 0);
    check("noovf_flag", overflow, 0);
    check("noovf_result_kept", result, 256);
    prev_res = 256;
`endif

    // Abort at integrate count 300
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 1; i < 300; i++) step(0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    check("abort_finished", finished_counting, 0);
    check("abort_result_kept", result, prev_res);
    check("abort_valid", result_valid, 0);

    // Discharge on the same cycle the count sits at full scale
    integrate(0, n);
    step(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < MAXV; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    check("sat_cap_result", result, 1023);
    check("sat_cap_overflow", overflow, 0);
    check("sat_cap_valid", result_valid, 1);

    // Random traffic against the model
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8000; i++)
      step(($urandom % 8000) == 0, ($urandom % 2500) == 0, ($urandom % 100) < 85,
           $urandom % 2, $urandom % 2, ($urandom % 300) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_slope_counter.md
# dual_slope_counter

Counting stage of the dual-slope ADC, directly downstream of the control machine. Consumes its `enable_counting`, `reset` and phase-select strobes. Times a fixed integration window and reports it via `finished_counting`. Measures the de-integration time until the comparator reports `cap_discharged`, then latches that count as the conversion result.

## Interface
- `WIDTH`, 10: counter and result width in bits.
- `N_INT`, 512: integration window in enabled clock cycles; legal range 1 ≤ N_INT ≤ 2^WIDTH−1.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: one clock; reset is synchronous and active-low.
- `count_clear` in 1: the control machine's `reset` output; synchronous, active-high clear.
- `enable_counting` in 1: count qualifier from the control machine.
- `ch_Vmeasured` in 1: integrate-phase select from the control machine.
- `ch_Vref` in 1: de-integrate-phase select from the control machine.
- `cap_discharged` in 1: comparator output; high when the integrator reaches zero.
- `finished_counting` out 1: integration window complete; to the control machine.
- `result` out WIDTH: last conversion count.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `overflow` out 1: last conversion timed out; sticky until the next conversion starts.

## Operation
- Priority: `reset_n` low > `count_clear` > state logic.
- `reset_n` low: state IDLE, count 0, `finished_counting` 0, `result` 0, `result_valid` 0, `overflow` 0.
- `count_clear`: state IDLE, count 0, `finished_counting` 0, `result_valid` 0. `result` and `overflow` are retained.
- States: IDLE, INTEGRATE, INT_DONE, DEINTEGRATE, DONE.
- IDLE → INTEGRATE:
  - Condition: `enable_counting` && `ch_Vmeasured`.
  - Count becomes 1, so the entry cycle is counted.
  - `overflow` clears.
- INTEGRATE:
  - Each cycle with `enable_counting`=1: count+1. `enable_counting`=0 pauses the count.
  - When an enabled cycle makes count == N_INT: `finished_counting` ← 1, count ← 0, go to INT_DONE.
- INT_DONE:
  - `finished_counting` held high.
  - On `enable_counting` && `ch_Vref`: `finished_counting` ← 0, count ← 0, go to DEINTEGRATE. This cycle is not counted.
- DEINTEGRATE:
  - If `cap_discharged`=1: `result` ← count, `result_valid` pulse, go to DONE.
  - Else, if `enable_counting`=1: count+1.
- DONE: idle until `count_clear`. Only IDLE accepts a new conversion.
- Phase inputs are sampled only at the IDLE and INT_DONE transitions. Changes mid-phase are ignored.
- `cap_discharged` outside DEINTEGRATE is ignored.
- Arithmetic: unsigned, WIDTH bits, no wrap (see Configuration). Result for input Vin is ≈ N_INT·Vin/Vref.

## Timing
- `finished_counting` rises on the edge that registers the N_INT-th enabled integrate cycle. It falls one cycle after the phase switch is seen.
- Result latency: `result`/`result_valid` are valid on the edge after the first cycle in which `cap_discharged`=1 is sampled in DEINTEGRATE.
- `result_valid` is exactly one cycle wide.
- Simultaneous `cap_discharged` and the saturation point: discharge wins; `result` = count, `overflow` = 0.
- `count_clear` mid-conversion aborts it within one cycle. No `result_valid` is produced.

## Configuration
- Macro: `DUAL_SLOPE_OVERFLOW_EN`.
- Defined:
  - In DEINTEGRATE, when count == 2^WIDTH−1 and `cap_discharged`=0 on an enabled cycle: `result` ← 2^WIDTH−1, `overflow` ← 1, `result_valid` pulse, go to DONE.
- Undefined:
  - `overflow` is tied 0.
  - Count saturates at 2^WIDTH−1 and the block waits in DEINTEGRATE for `cap_discharged` or `count_clear`.

## Structure
- Package `dual_slope_pkg` holds:
  - state enum (IDLE, INTEGRATE, INT_DONE, DEINTEGRATE, DONE);
  - default constants `DS_WIDTH`=10 and `DS_N_INT`=512;
  - the `N_INT` legality check.
- One sub-module, `ds_up_counter`: saturating WIDTH-bit up-counter with synchronous clear, load-1, enable, and an at-max flag. The FSM lives in `dual_slope_counter`.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with random inputs → all outputs 0, state IDLE.
- Integration window:
  - Stimulus: N_INT=512, `enable_counting` and `ch_Vmeasured` held high.
  - Expect: `finished_counting` rises exactly 512 cycles after entry.
  - Repeat with 10 `enable_counting` gaps: rise is delayed by 10 cycles.
- Half-scale conversion:
  - Stimulus: switch to `ch_Vref`; assert `cap_discharged` after 256 enabled DEINTEGRATE cycles.
  - Expect: `result`=256, `result_valid` high for 1 cycle, `overflow`=0.
- Overflow (macro defined):
  - Stimulus: WIDTH=10, never assert `cap_discharged`.
  - Expect: `result`=1023, `overflow`=1, `result_valid` pulse.
  - Macro undefined: no `result_valid`, `overflow` stays 0.
- Abort: `count_clear` at integrate count 300 → IDLE next cycle, `finished_counting` 0, previous `result` retained, no `result_valid`.
- Edge cases:
  - `cap_discharged` on the same cycle as saturation → `result`=1023, `overflow`=0.
  - `cap_discharged` during INTEGRATE → ignored.
